writeback_arbiter: RTL and testbench

//  Write-back stage directly upstream of the 32x32 register file. Accepts results from
//  two producers (ALU, LSU), buffers each in its own FIFO, round-robin arbitrates
//  one write per cycle and drives the register-file write port (w_enable/w_addr/w_data).

---
 rtl/writeback_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Write-back stage: per-source result FIFOs, round-robin arbitration
// onto the single register-file write port, plus a RAW pending query.

module wb_fifo #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  input  logic [AW-1:0] q_addr_i,
  output logic          q_hit_o
);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] off;

  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_q] <= addr_i;
      data_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Power-of-2 depth lets pointers wrap by plain overflow.
  always_comb begin
    wr_d    = push_i ? wr_q + 1'b1 : wr_q;
    rd_d    = pop_i  ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  // A slot is live when its distance from the read pointer is below occupancy.
  always_comb begin
    q_hit_o = 1'b0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_q;
      if ((CW'(off) < count_q) && (addr_q[i] == q_addr_i))
        q_hit_o = 1'b1;
    end
  end

  assign head_addr_o = addr_q[rd_q];
  assign head_data_o = data_q[rd_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == CW'(DEPTH));

endmodule

module writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_pending,
  output logic [CW-1:0]     alu_count,
  output logic [CW-1:0]     lsu_count
);

  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  logic              alu_full, lsu_full;
  logic              alu_push, lsu_push;
  logic              alu_pop, lsu_pop;
  logic              alu_hit, lsu_hit;
  logic [ADDR_W-1:0] alu_haddr, lsu_haddr;
  logic [DATA_W-1:0] alu_hdata, lsu_hdata;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              alu_ne, lsu_ne;

  assign alu_ready = ~rst & ~alu_full;
  assign lsu_ready = ~rst & ~lsu_full;
  assign alu_push  = alu_valid & alu_ready;
  assign lsu_push  = lsu_valid & lsu_ready;

  wb_fifo #(.DW(DATA_W), .AW(ADDR_W), .DEPTH(DEPTH)) u_alu_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (alu_push),
    .addr_i      (alu_addr),
    .data_i      (alu_data),
    .pop_i       (alu_pop),
    .head_addr_o (alu_haddr),
    .head_data_o (alu_hdata),
    .count_o     (alu_count),
    .full_o      (alu_full),
    .q_addr_i    (q_addr),
    .q_hit_o     (alu_hit)
  );

  wb_fifo #(.DW(DATA_W), .AW(ADDR_W), .DEPTH(DEPTH)) u_lsu_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (lsu_push),
    .addr_i      (lsu_addr),
    .data_i      (lsu_data),
    .pop_i       (lsu_pop),
    .head_addr_o (lsu_haddr),
    .head_data_o (lsu_hdata),
    .count_o     (lsu_count),
    .full_o      (lsu_full),
    .q_addr_i    (q_addr),
    .q_hit_o     (lsu_hit)
  );

  // Occupancy is registered, so a fresh push is never popped in its own cycle.
  assign alu_ne = (alu_count != '0);
  assign lsu_ne = (lsu_count != '0);

  always_comb begin
    alu_pop = 1'b0;
    lsu_pop = 1'b0;
    last_d  = last_q;
    if (alu_ne && lsu_ne) begin
      if (last_q == GNT_LSU) begin
        alu_pop = 1'b1;
        last_d  = GNT_ALU;
      end else begin
        lsu_pop = 1'b1;
        last_d  = GNT_LSU;
      end
    end else if (alu_ne) begin
      alu_pop = 1'b1;
    end else if (lsu_ne) begin
      lsu_pop = 1'b1;
    end
  end

  always_comb begin
    we_d = alu_pop | lsu_pop;
    wa_d = wa_q;
    wd_d = wd_q;
    if (alu_pop) begin
      wa_d = alu_haddr;
      wd_d = alu_hdata;
    end else if (lsu_pop) begin
      wa_d = lsu_haddr;
      wd_d = lsu_hdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GNT_LSU;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
    end
  end

  assign w_enable  = we_q;
  assign w_addr    = wa_q;
  assign w_data    = wd_q;
  assign q_pending = alu_hit | lsu_hit | (we_q && (wa_q == q_addr));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, latency, alternation,
// fill/drain order, hazard query and mid-run reset.

module tb_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        w_enable;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [4:0]  q_addr;
  logic        q_pending;
  logic [2:0]  alu_count, lsu_count;

  int pass_cnt;
  int total_cnt;

  logic [36:0] wq[$];

  writeback_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .w_enable  (w_enable),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .q_addr    (q_addr),
    .q_pending (q_pending),
    .alu_count (alu_count),
    .lsu_count (lsu_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk)
    if (!rst && w_enable) wq.push_back({w_addr, w_data});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wq.delete();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    #1;
    total_cnt++;
    if ({w_enable, alu_count, lsu_count, alu_ready, lsu_ready} !== 9'b0)
      $display("FAIL reset_state: got we=%b ac=%0d lc=%0d ar=%b lr=%b want all 0",
               w_enable, alu_count, lsu_count, alu_ready, lsu_ready);
    else pass_cnt++;
    total_cnt++;
    if ({w_addr, w_data} !== 37'b0)
      $display("FAIL reset_wport: got addr=%0d data=%0h want 0/0", w_addr, w_data);
    else pass_cnt++;
    step();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({alu_ready, lsu_ready} !== 2'b11)
      $display("FAIL reset_release_ready: got %b%b want 11", alu_ready, lsu_ready);
    else pass_cnt++;
    wq.delete();
  endtask

  task automatic test_single();
    do_reset();
    alu_valid = 1'b1;
    alu_addr  = 5'd10;
    alu_data  = 32'd1000;
    step();
    alu_valid = 1'b0;
    total_cnt++;
    if (w_enable !== 1'b0 || alu_count !== 3'd1)
      $display("FAIL single_no_bypass: got we=%b cnt=%0d want 0/1", w_enable, alu_count);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({w_enable, w_addr, w_data} !== {1'b1, 5'd10, 32'd1000})
      $display("FAIL single_write: got we=%b addr=%0d data=%0d want 1/10/1000",
               w_enable, w_addr, w_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (w_enable !== 1'b0 || w_addr !== 5'd10 || alu_count !== 3'd0)
      $display("FAIL single_after: got we=%b addr=%0d cnt=%0d want 0/10/0",
               w_enable, w_addr, alu_count);
    else pass_cnt++;
  endtask

  task automatic test_alternate();
    logic [36:0] exp_q[$];
    exp_q = '{{5'd20, 32'd2000}, {5'd15, 32'd3000}, {5'd21, 32'd2001},
              {5'd15, 32'd3001}, {5'd22, 32'd2002}, {5'd15, 32'd3002}};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1;
      alu_addr  = 5'(20 + i);
      alu_data  = 32'(2000 + i);
      lsu_valid = 1'b1;
      lsu_addr  = 5'd15;
      lsu_data  = 32'(3000 + i);
      step();
    end
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    repeat (8) step();
    total_cnt++;
    if (wq.size() != 6)
      $display("FAIL alt_count: got %0d writes want 6", wq.size());
    else pass_cnt++;
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      total_cnt++;
      if (wq[i] !== exp_q[i])
        $display("FAIL alt_order[%0d]: got %0h want %0h", i, wq[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] a_seen[$];
    logic [31:0] l_seen[$];
    do_reset();
    for (int i = 0; i < 7; i++) begin
      alu_valid = 1'b1;
      alu_addr  = 5'(1 + i);
      alu_data  = 32'(32'hA0 + i);
      lsu_valid = (i < 6);
      lsu_addr  = 5'(16 + i);
      lsu_data  = 32'(32'hB0 + i);
      if (i == 6) begin
        total_cnt++;
        if (lsu_ready !== 1'b0 || lsu_count !== 3'd4)
          $display("FAIL fill_lsu_full: got rdy=%b cnt=%0d want 0/4", lsu_ready, lsu_count);
        else pass_cnt++;
      end
      step();
    end
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    total_cnt++;
    if (alu_count !== 3'd4 || alu_ready !== 1'b0 || lsu_count !== 3'd3)
      $display("FAIL fill_alu_full: got ac=%0d rdy=%b lc=%0d want 4/0/3",
               alu_count, alu_ready, lsu_count);
    else pass_cnt++;
    repeat (12) step();
    foreach (wq[i]) begin
      if (wq[i][36:32] < 5'd16) a_seen.push_back(wq[i][31:0]);
      else l_seen.push_back(wq[i][31:0]);
    end
    total_cnt++;
    if (a_seen.size() != 7 || l_seen.size() != 6)
      $display("FAIL drain_count: got alu=%0d lsu=%0d want 7/6", a_seen.size(), l_seen.size());
    else pass_cnt++;
    for (int i = 0; i < a_seen.size() && i < 7; i++) begin
      total_cnt++;
      if (a_seen[i] !== 32'(32'hA0 + i))
        $display("FAIL drain_alu[%0d]: got %0h want %0h", i, a_seen[i], 32'hA0 + i);
      else pass_cnt++;
    end
    for (int i = 0; i < l_seen.size() && i < 6; i++) begin
      total_cnt++;
      if (l_seen[i] !== 32'(32'hB0 + i))
        $display("FAIL drain_lsu[%0d]: got %0h want %0h", i, l_seen[i], 32'hB0 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_pending();
    do_reset();
    lsu_valid = 1'b1;
    lsu_addr  = 5'd30;
    lsu_data  = 32'h1234;
    q_addr    = 5'd30;
    step();
    lsu_valid = 1'b0;
    total_cnt++;
    if (q_pending !== 1'b1 || w_enable !== 1'b0)
      $display("FAIL pend_queued: got pend=%b we=%b want 1/0", q_pending, w_enable);
    else pass_cnt++;
    q_addr = 5'd31;
    #1;
    total_cnt++;
    if (q_pending !== 1'b0)
      $display("FAIL pend_other: got %b want 0", q_pending);
    else pass_cnt++;
    q_addr = 5'd30;
    step();
    total_cnt++;
    if (q_pending !== 1'b1 || w_enable !== 1'b1 || lsu_count !== 3'd0)
      $display("FAIL pend_writing: got pend=%b we=%b cnt=%0d want 1/1/0",
               q_pending, w_enable, lsu_count);
    else pass_cnt++;
    step();
    total_cnt++;
    if (q_pending !== 1'b0 || w_enable !== 1'b0)
      $display("FAIL pend_cleared: got pend=%b we=%b want 0/0", q_pending, w_enable);
    else pass_cnt++;
  endtask

  task automatic test_addr_zero();
    do_reset();
    alu_valid = 1'b1;
    alu_addr  = 5'd0;
    alu_data  = 32'hDEAD;
    step();
    alu_valid = 1'b0;
    step();
    total_cnt++;
    if ({w_enable, w_addr, w_data} !== {1'b1, 5'd0, 32'hDEAD})
      $display("FAIL addr_zero: got we=%b addr=%0d data=%0h want 1/0/dead",
               w_enable, w_addr, w_data);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1;
      alu_addr  = 5'd5;
      alu_data  = 32'(32'h55 + i);
      lsu_valid = 1'b1;
      lsu_addr  = 5'd6;
      lsu_data  = 32'(32'h66 + i);
      step();
    end
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    total_cnt++;
    if (alu_count !== 3'd2 || lsu_count !== 3'd2)
      $display("FAIL mid_queued: got ac=%0d lc=%0d want 2/2", alu_count, lsu_count);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({alu_count, lsu_count, w_enable, alu_ready, lsu_ready} !== 9'b0)
      $display("FAIL mid_reset_now: got ac=%0d lc=%0d we=%b rdy=%b%b want 0",
               alu_count, lsu_count, w_enable, alu_ready, lsu_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wq.delete();
    repeat (6) step();
    total_cnt++;
    if (wq.size() != 0 || w_enable !== 1'b0)
      $display("FAIL mid_no_ghost: got %0d writes we=%b want 0/0", wq.size(), w_enable);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    lsu_addr  = '0;
    lsu_data  = '0;
    q_addr    = '0;
    test_reset();
    test_single();
    test_alternate();
    test_fill_drain();
    test_pending();
    test_addr_zero();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
